// File: rtl/pdm_tx.sv
// pdm_tx -- first-order sigma-delta PCM-to-PDM modulator.
//
// One signed 16-bit PCM sample is accepted per frame and turned into
// FRAME_LEN PDM bits, followed by a single-cycle end-of-frame strobe for
// a downstream decimation filter. The accumulator is kept across frames
// (only reset clears it), so quantisation error carries into the next
// sample and the noise shaping stays continuous.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   din        signed two's-complement PCM sample
//   din_valid  upstream sample available
//   din_ready  block can accept a sample (only in IDLE)
//   en         bit-rate enable; 0 pauses modulation
//   bit_out    PDM bit (0 whenever bit_valid is 0)
//   bit_valid  bit_out is a valid stream bit this cycle
//   filter     one-cycle end-of-frame strobe
//   busy       high whenever the FSM is not IDLE
//
// Handshake: a sample transfers on a rising edge where din_valid and
// din_ready are both high. din_ready depends only on registered state,
// never on din_valid, and din_valid seen outside IDLE is ignored.
//
// FSM: IDLE -> MOD on accept; MOD -> STROBE after the last bit of the
// frame; STROBE -> IDLE unconditionally one cycle later.

module pdm_tx #(
  parameter int FRAME_LEN = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        en,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        filter,
  output logic        busy
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOD    = 2'd1,
    STROBE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [15:0]       acc_q;
  logic [15:0]       sample_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [16:0]       sum;

  // The carry out of acc + sample is the PDM bit: it fires once for every
  // 2^16 of accumulated sample value, giving ones density u/65536.
  assign sum = {1'b0, acc_q} + {1'b0, sample_q};

  always_comb begin
    state_d   = state_q;
    din_ready = 1'b0;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    filter    = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        din_ready = 1'b1;
        busy      = 1'b0;
        if (din_valid) state_d = MOD;
      end
      MOD: begin
        bit_valid = en;
        bit_out   = en & sum[16];
        if (en && (bit_cnt_q == LAST_BIT)) state_d = STROBE;
      end
      STROBE: begin
        filter  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= 16'd0;
      sample_q  <= 16'd0;
      bit_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && din_valid) begin
        // Adding 32768 to a 16-bit two's-complement value is the same as
        // inverting its sign bit; this maps -32768..32767 onto 0..65535.
        sample_q  <= {~din[15], din[14:0]};
        bit_cnt_q <= '0;
      end
      if ((state_q == MOD) && en) begin
        acc_q     <= sum[15:0];
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/pdm_tx.md
PDM_TX -- requirements
Module: pdm_tx

Interface
REQ-001 Parameter FRAME_LEN, default 512, SHALL set the number of PDM bits emitted per accepted sample; it is a power of two, 2..4096.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 din  input  16  signed two's-complement PCM sample.
REQ-005 din_valid  input  1  upstream sample available.
REQ-006 din_ready  output  1  block can accept a sample.
REQ-007 en  input  1  bit-rate enable; 0 pauses modulation.
REQ-008 bit_out  output  1  PDM bit for the filter's bit_in.
REQ-009 bit_valid  output  1  bit_out is a valid stream bit this cycle.
REQ-010 filter  output  1  one-cycle end-of-frame strobe for the filter's filter input.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, MOD and STROBE, with all outputs decoded combinationally from registered state.
REQ-013 IDLE: din_ready=1; on din_valid&din_ready, capture u = din + 32768 as a 16-bit unsigned value (sign bit inverted) into sample_q, clear bit_cnt, go to MOD.
REQ-014 IDLE without din_valid SHALL remain in IDLE.
REQ-015 MOD: din_ready=0; {carry, sum} = acc (16-bit unsigned) + sample_q is formed as a 17-bit result; bit_out=carry; bit_valid=en.
REQ-016 MOD with en=1: at the clock edge acc<=sum (modulo 2^16) and bit_cnt increments; with en=0, acc, bit_cnt and state hold.
REQ-017 MOD with en=1 and bit_cnt==FRAME_LEN-1: go to STROBE; exactly FRAME_LEN bit_valid cycles occur per sample.
REQ-018 STROBE: filter=1, bit_valid=0, din_ready=0, lasting exactly one cycle independent of en, then go to IDLE.
REQ-019 filter SHALL be 0 in all states other than STROBE.
REQ-020 bit_out SHALL be 0 whenever bit_valid=0.
REQ-021 acc SHALL be retained across frames and cleared only by reset, so noise shaping is continuous.
REQ-022 The ones density over a frame SHALL equal floor or ceil of FRAME_LEN*u/65536, given continuous acc.
REQ-023 din_valid asserted in MOD or STROBE SHALL NOT be accepted; it is accepted on the first IDLE cycle.
REQ-024 The minimum sample period SHALL be FRAME_LEN+2 cycles: 1 IDLE, FRAME_LEN MOD, 1 STROBE.
REQ-025 Latency: a handshake at edge T SHALL make the first bit_valid cycle the one following edge T when en=1.

Reset
REQ-026 While rst=1: state=IDLE, acc=0, sample_q=0, bit_cnt=0.
REQ-027 Outputs under reset: din_ready=1, bit_valid=0, bit_out=0, filter=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no filter strobe; the next frame starts with acc=0.

Verification
REQ-029 After reset, din=0x0000 accepted, en=1: bit_out sequence is 0,1,0,1,...; 256 ones in 512 bits; filter high exactly one cycle after the 512th bit.
REQ-030 din=0x8000 (-32768): 512 bits, all 0; din=0x7FFF after reset: first bit 0, then 511 ones total in the frame.
REQ-031 din=0x4000, en toggled 1,0 every cycle: bit_valid=0 on en=0 cycles; 512 valid bits containing 384 ones; frame spans 1024 MOD cycles.
REQ-032 din_valid held high continuously with incrementing din: one accept every 514 cycles; din_ready=0 throughout MOD and STROBE; no sample lost or duplicated.
REQ-033 rst pulsed at bit 100 of a frame: outputs take reset values asynchronously; no filter pulse; the next frame with din=0 reproduces the REQ-029 pattern.
REQ-034 FRAME_LEN=8, din=0x0000: 8 bits 0,1,0,1,0,1,0,1, then filter, then din_ready on the following cycle.
